instr_prefetch: RTL
===================

Name: instr_prefetch

Overview:
- Instruction prefetch queue between the fetch PC logic and decode.
- Replaces the direct combinational PC-to-instruction-memory path, so instruction memory can have variable, multi-cycle latency.
- Issues sequential word fetches, buffers returned instructions with their PCs in program order, and presents them to decode through a valid/ready handshake.
- A branch/jump redirect flushes the queue and drops in-flight responses.

Parameters:
- DATA_WIDTH, 32, width of instructions, PCs and memory address/data.
- DEPTH, 4, number of queue entries; power of two, 2 to 16; also the maximum number of outstanding memory requests.
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect  input  1  one-cycle pulse from decode/execute: flush and restart at redirect_pc.
- redirect_pc  input  DATA_WIDTH  new fetch address; bits [1:0] are ignored and treated as 0.
- mem_req  output  1  fetch request valid.
- mem_addr  output  DATA_WIDTH  fetch word address; always 4-byte aligned.
- mem_ready  input  1  memory accepts the request this cycle when mem_req && mem_ready.
- mem_rvalid  input  1  response valid; responses return in request order, latency ≥1 cycle, unbounded.
- mem_rdata  input  DATA_WIDTH  instruction word for the oldest outstanding request.
- out_valid  output  1  head entry holds a filled instruction.
- out_instr  output  DATA_WIDTH  head instruction.
- out_pc  output  DATA_WIDTH  PC of the head instruction.
- out_ready  input  1  decode consumes the head when out_valid && out_ready.

Behaviour:
- State:
  - fetch_pc register.
  - DEPTH-entry ring holding pc, instr and filled flag per entry.
  - Pointers: head (pop), fill (next entry to fill), tail (next entry to allocate); each is log2(DEPTH)+1 bits and wraps naturally.
  - stale counter, 0..DEPTH: in-flight responses to be discarded.
- Reset (rst=1 at a clock edge):
  - fetch_pc=RESET_PC.
  - Pointers=0, stale=0, all filled flags=0.
  - Outputs during and after reset: out_valid=0, mem_req=0.
  - Memory is reset by the same rst, so no pre-reset responses arrive afterwards.
  - Reset mid-operation discards everything, with no other side effects.
- Request issue:
  - mem_req = !rst && !redirect && ((tail-head) + stale < DEPTH).
  - mem_addr = fetch_pc.
  - On mem_req && mem_ready: allocate the entry at tail (pc=fetch_pc, filled=0), tail+=1, fetch_pc+=4 (modulo 2^DATA_WIDTH, wraps to 0).
  - mem_req may stay high while mem_ready=0; mem_addr must then hold stable.
- Response:
  - On mem_rvalid with stale>0: discard the data, stale-=1.
  - On mem_rvalid with stale=0: write instr at fill, set filled, fill+=1.
  - mem_rvalid with no outstanding request is a protocol error; behaviour is undefined and the bench must not generate it.
- Output (registered, no bypass):
  - out_valid = filled[head] && (head!=tail) && !redirect.
  - out_instr and out_pc come from the head entry.
  - Minimum latency from issue to out_valid is 2 cycles with 1-cycle memory: request in cycle N, rvalid in N+1, out_valid in N+2.
  - Sustained throughput is 1 instruction/cycle with 1-cycle memory when DEPTH≥3 and out_ready=1.
- Pop: on out_valid && out_ready, clear filled[head], head+=1.
- Redirect (highest priority after rst):
  - In the redirect cycle, mem_req=0 and out_valid=0, so no pop occurs.
  - fetch_pc={redirect_pc[DATA_WIDTH-1:2],2'b00}.
  - stale_next = stale + (tail-fill) - (mem_rvalid ? 1 : 0); this counts the same-cycle response as consumed/dropped.
  - All filled flags are cleared and head=fill=tail.
  - Back-to-back redirects accumulate stale correctly. stale never exceeds DEPTH, because the issue condition bounds occupancy + stale.
- Simultaneous events:
  - Issue, fill and pop in the same cycle are all legal and independent.
  - A fill into the head entry in cycle N makes out_valid rise in N+1.
- Full: when (tail-head)+stale==DEPTH, mem_req=0 until a pop or a stale drop frees a slot.
- Empty: head==tail gives out_valid=0.

Test Plan:
- Reset, then 1-cycle memory returning mem[a]=a^32'hA5A5_0000 and out_ready=1 -> out_pc sequence 0,4,8,12,… with matching out_instr; first out_valid 2 cycles after rst deasserts; one instruction per cycle thereafter.
- out_ready=0 for 10 cycles with 1-cycle memory -> exactly DEPTH=4 requests (0x0..0xC) issued, then mem_req=0; releasing out_ready yields 0x0,0x4,0x8,0xC in order with no loss.
- 3-cycle latency memory with 3 requests in flight; pulse redirect to redirect_pc=0x103 -> the 3 stale responses are dropped; next out_pc=0x100, then 0x104; no instruction from the old path appears.
- redirect in the same cycle as a mem_rvalid and as out_valid&&out_ready -> the popped entry is not consumed (out_valid=0 that cycle); stale count excludes the coincident response; the first post-redirect instruction is correct.
- mem_ready toggling 1,0,0,1 with fetch_pc=0xFFFF_FFFC via redirect -> mem_addr holds stable while stalled; next address wraps to 0x0000_0000.
- Assert rst mid-stream with 2 requests in flight and 2 filled entries -> next cycle out_valid=0, mem_req=0; after release the fetch restarts at RESET_PC with stale=0.

Source files
------------

// File: rtl/instr_prefetch.sv
// instr_prefetch: instruction prefetch queue between fetch-PC logic and decode.
// Issues sequential word fetches to a variable-latency instruction memory,
// buffers returned words with their PCs in program order, and hands them to
// decode over a valid/ready handshake. A redirect flushes the queue and
// marks every in-flight response as stale so it is silently dropped.
module instr_prefetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [DATA_WIDTH-1:0] out_pc,
    input  logic                  out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);
    localparam logic [PW+1:0]         BUDGET  = DEPTH[PW+1:0];

    typedef logic [PW:0]   ptr_t;
    typedef logic [PW-1:0] idx_t;

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    ptr_t                  head_q, head_d;
    ptr_t                  fill_q, fill_d;
    ptr_t                  tail_q, tail_d;
    ptr_t                  stale_q, stale_d;
    logic [DEPTH-1:0]      filled_q, filled_d;
    logic [DATA_WIDTH-1:0] pc_q    [DEPTH];
    logic [DATA_WIDTH-1:0] instr_q [DEPTH];

    idx_t          head_idx, fill_idx, tail_idx;
    ptr_t          occupancy;
    ptr_t          inflight;
    logic [PW+1:0] committed;
    logic          do_issue, do_pop, do_fill, do_drop;
    logic [1:0]    redirect_pc_unused;

    // The low address bits of a redirect target are ignored; word alignment is forced.
    assign redirect_pc_unused = redirect_pc[1:0];

    assign head_idx = head_q[PW-1:0];
    assign fill_idx = fill_q[PW-1:0];
    assign tail_idx = tail_q[PW-1:0];

    // Allocated entries plus responses still owed to the old path must fit in
    // the queue, which also caps the number of outstanding memory requests.
    assign occupancy = tail_q - head_q;
    assign inflight  = tail_q - fill_q;
    assign committed = {1'b0, occupancy} + {1'b0, stale_q};

    assign mem_req   = !rst && !redirect && (committed < BUDGET);
    assign mem_addr  = fetch_pc_q;

    assign out_valid = !rst && !redirect && filled_q[head_idx] && (head_q != tail_q);
    assign out_instr = instr_q[head_idx];
    assign out_pc    = pc_q[head_idx];

    assign do_issue = mem_req && mem_ready;
    assign do_pop   = out_valid && out_ready;
    assign do_drop  = mem_rvalid && (stale_q != '0);
    assign do_fill  = mem_rvalid && (stale_q == '0) && !redirect;

    // Next-state for fetch PC, ring pointers, stale counter and filled flags.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        fill_d     = fill_q;
        tail_d     = tail_q;
        stale_d    = stale_q;
        filled_d   = filled_q;
        if (redirect) begin
            // Every request not yet filled becomes stale; a response arriving
            // this very cycle is already accounted for by dropping it now.
            fetch_pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            stale_d    = stale_q + inflight - ptr_t'(mem_rvalid);
            head_d     = tail_q;
            fill_d     = tail_q;
            filled_d   = '0;
        end else begin
            if (do_issue) begin
                tail_d             = tail_q + ptr_t'(1);
                fetch_pc_d         = fetch_pc_q + PC_STEP;
                filled_d[tail_idx] = 1'b0;
            end
            if (do_pop) begin
                head_d             = head_q + ptr_t'(1);
                filled_d[head_idx] = 1'b0;
            end
            if (do_drop) begin
                stale_d = stale_q - ptr_t'(1);
            end
            if (do_fill) begin
                fill_d             = fill_q + ptr_t'(1);
                filled_d[fill_idx] = 1'b1;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            stale_q    <= '0;
            filled_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            fill_q     <= fill_d;
            tail_q     <= tail_d;
            stale_q    <= stale_d;
            filled_q   <= filled_d;
        end
    end

    // Entry payload: PC captured at issue, instruction captured at fill; the
    // filled flags alone decide validity, so the payload needs no reset.
    always_ff @(posedge clk) begin
        if (do_issue) begin
            pc_q[tail_idx] <= fetch_pc_q;
        end
        if (do_fill) begin
            instr_q[fill_idx] <= mem_rdata;
        end
    end

endmodule
